// File: rtl/axi_lite_bram_slave_pkg.sv
// Shared types for the AXI4-Lite data-memory slave.
// Response codes and the read/write FSM state encodings.
package axi_lite_bram_slave_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COMMIT,
      W_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_MEM,
      R_WAIT,
      R_RESP
   } rd_state_t;

endpackage

// File: rtl/axi_lite_bram_slave_if.sv
// AXI4-Lite ar/r/aw/w/b channel bundle between the core's MEM stage
// and the data-memory slave.
interface axi_lite_bram_slave_if;

   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arprot, arvalid, rready,
      output awaddr, awprot, awvalid,
      output wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arprot, arvalid, rready,
      input  awaddr, awprot, awvalid,
      input  wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid,
      output awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/axi_lite_bram_slave.sv
// AXI4-Lite slave serving the data-memory bus from a single-port,
// 1-cycle-latency block RAM; writes win RAM-port contention.
module axi_lite_bram_slave
   import axi_lite_bram_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MEM_WORDS = 16384,
   parameter int          IDX_W     = 14
) (
   input  logic             clk,
   input  logic             rstn,
   axi_lite_bram_slave_if.slave s,
   output logic             mem_en,
   output logic [3:0]       mem_we,
   output logic [IDX_W-1:0] mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   function automatic logic f_in_range(input logic [31:0] a);
      logic [31:0] w_idx;
      w_idx = (a - BASE_ADDR) >> 2;
      return (a >= BASE_ADDR) && (w_idx < 32'(MEM_WORDS));
   endfunction

   function automatic logic [IDX_W-1:0] f_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   wr_state_t        r_wst;
   logic             r_aw_held;
   logic             r_w_held;
   logic             r_awready;
   logic             r_wready;
   logic             r_bvalid;
   logic [1:0]       r_bresp;
   logic [31:0]      r_awaddr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;

   rd_state_t        r_rst;
   logic             r_arready;
   logic             r_rvalid;
   logic [1:0]       r_rresp;
   logic [31:0]      r_araddr;
   logic [31:0]      r_rdata;
   logic [IDX_W-1:0] r_mem_addr;

   logic w_aw_hs;
   logic w_w_hs;
   logic w_ar_hs;
   logic w_aw_held_n;
   logic w_w_held_n;
   logic w_go_commit;
   logic w_commit;
   logic w_wr_ok;
   logic w_rd_ok;
   logic [31:0] w_waddr;
   logic [31:0] w_raddr;
   logic w_unused;

   assign w_aw_hs     = s.awvalid & r_awready;
   assign w_w_hs      = s.wvalid & r_wready;
   assign w_ar_hs     = s.arvalid & r_arready;
   assign w_aw_held_n = r_aw_held | w_aw_hs;
   assign w_w_held_n  = r_w_held | w_w_hs;
   assign w_go_commit = (r_wst == W_IDLE) & w_aw_held_n & w_w_held_n;
   assign w_commit    = (r_wst == W_COMMIT);
   assign w_wr_ok     = f_in_range(r_awaddr);
   assign w_rd_ok     = f_in_range(r_araddr);
   assign w_waddr     = w_aw_hs ? s.awaddr : r_awaddr;
   assign w_raddr     = w_ar_hs ? s.araddr : r_araddr;
   assign w_unused    = &{1'b0, s.arprot, s.awprot};

   // A read sitting in R_MEM yields the port to a committing write.
   assign mem_en    = (w_commit & w_wr_ok)
                    | ((r_rst == R_MEM) & ~w_commit);
   assign mem_we    = (w_commit & w_wr_ok) ? r_wstrb : 4'b0000;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_wdata;

   assign s.awready = r_awready;
   assign s.wready  = r_wready;
   assign s.bvalid  = r_bvalid;
   assign s.bresp   = r_bresp;
   assign s.arready = r_arready;
   assign s.rvalid  = r_rvalid;
   assign s.rdata   = r_rdata;
   assign s.rresp   = r_rresp;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wst     <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awready <= 1'b1;
         r_wready  <= 1'b1;
         r_bvalid  <= 1'b0;
         r_bresp   <= AXI_RESP_OKAY;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         if (w_aw_hs) r_awaddr <= s.awaddr;
         if (w_w_hs) begin
            r_wdata <= s.wdata;
            r_wstrb <= s.wstrb;
         end
         unique case (r_wst)
            W_IDLE: begin
               r_aw_held <= w_aw_held_n;
               r_w_held  <= w_w_held_n;
               r_awready <= ~w_aw_held_n;
               r_wready  <= ~w_w_held_n;
               if (w_go_commit) r_wst <= W_COMMIT;
            end
            W_COMMIT: begin
               r_bvalid <= 1'b1;
               r_bresp  <= w_wr_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
               r_wst    <= W_RESP;
            end
            W_RESP: begin
               if (s.bready) begin
                  r_bvalid  <= 1'b0;
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wst     <= W_IDLE;
               end
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rst     <= R_IDLE;
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rresp   <= AXI_RESP_OKAY;
         r_rdata   <= '0;
         r_araddr  <= '0;
      end else begin
         unique case (r_rst)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_araddr  <= s.araddr;
                  r_arready <= 1'b0;
                  r_rst     <= f_in_range(s.araddr) ? R_MEM : R_WAIT;
               end
            end
            R_MEM: begin
               if (!w_commit) r_rst <= R_WAIT;
            end
            R_WAIT: begin
               r_rdata  <= w_rd_ok ? mem_rdata : 32'h0;
               r_rresp  <= w_rd_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
               r_rvalid <= 1'b1;
               r_rst    <= R_RESP;
            end
            R_RESP: begin
               if (s.rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rst     <= R_IDLE;
               end
            end
            default: r_rst <= R_IDLE;
         endcase
      end
   end

   // Address for next cycle: a commit about to start takes the port.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_mem_addr <= '0;
      end else if (w_go_commit) begin
         r_mem_addr <= f_idx(w_waddr);
      end else begin
         r_mem_addr <= f_idx(w_raddr);
      end
   end

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
// Bench for axi_lite_bram_slave: vector table plus response scoreboard,
// paired with a behavioural single-port RAM.
module bram_sp_model #(
   parameter int WORDS = 16384,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [WORDS];
   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
   end
   always @(posedge clk) begin
      if (en) begin
         if (we == 4'b0000) rdata <= mem[addr];
         else begin
            for (int b = 0; b < 4; b++)
               if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end
endmodule

module tb_axi_lite_bram_slave;
   import axi_lite_bram_slave_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   axi_lite_bram_slave_if bus();

   axi_lite_bram_slave dut (
      .clk       (clk),
      .rstn      (rstn),
      .s         (bus),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   bram_sp_model #(.WORDS(16384), .AW(14)) ram (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          aw_dly;
      int          w_dly;
      logic [31:0] rd;
      logic [1:0]  resp;
   } vec_t;

   exp_t bq[$];
   exp_t rq[$];
   vec_t vt[9];

   int cyc = 0;
   int we_cnt = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (mem_we != 4'b0000) we_cnt <= we_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] st, input int aw_dly,
                              input int w_dly, input logic [1:0] er,
                              input string nm, output int hs);
      bit aw_done;
      bit w_done;
      int t;
      exp_t e;
      aw_done = 0;
      w_done = 0;
      t = 0;
      hs = -100;
      e.data = 32'h0;
      e.resp = er;
      bq.push_back(e);
      while (!(aw_done && w_done) && t < 40) begin
         @(negedge clk);
         bus.awaddr  = a;
         bus.wdata   = d;
         bus.wstrb   = st;
         bus.awvalid = !aw_done && (t >= aw_dly);
         bus.wvalid  = !w_done && (t >= w_dly);
         if (bus.awvalid && bus.awready) begin aw_done = 1; hs = cyc; end
         if (bus.wvalid && bus.wready) begin w_done = 1; hs = cyc; end
         t++;
      end
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!(aw_done && w_done)) chk({nm, "_accept_timeout"}, 0, 1);
   endtask

   task automatic wait_b(input int hs, input int hold, input string nm);
      int t;
      exp_t e;
      logic [1:0] r0;
      t = 0;
      while (!bus.bvalid && t < 20) begin @(negedge clk); t++; end
      if (!bus.bvalid) begin
         chk({nm, "_b_timeout"}, 0, 1);
         if (bq.size() > 0) e = bq.pop_front();
         return;
      end
      chk({nm, "_b_lat"}, 32'(cyc - hs), 2);
      r0 = bus.bresp;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_b_hold"},
             {27'h0, bus.bvalid, bus.bresp, bus.awready, bus.wready},
             {27'h0, 1'b1, r0, 2'b00});
      end
      e = bq.pop_front();
      chk({nm, "_bresp"}, {30'h0, bus.bresp}, {30'h0, e.resp});
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      chk({nm, "_b_done"}, {31'h0, bus.bvalid}, 0);
   endtask

   task automatic drive_read(input logic [31:0] a, input logic [31:0] ed,
                             input logic [1:0] er, input string nm,
                             output int hs);
      bit done;
      int t;
      exp_t e;
      done = 0;
      t = 0;
      hs = -100;
      e.data = ed;
      e.resp = er;
      rq.push_back(e);
      while (!done && t < 40) begin
         @(negedge clk);
         bus.araddr  = a;
         bus.arvalid = 1'b1;
         if (bus.arready) begin done = 1; hs = cyc; end
         t++;
      end
      @(negedge clk);
      bus.arvalid = 1'b0;
      if (!done) chk({nm, "_ar_timeout"}, 0, 1);
   endtask

   task automatic wait_r(input int hs, input int hold, input int lat,
                         input string nm);
      int t;
      exp_t e;
      logic [31:0] d0;
      logic [1:0]  r0;
      t = 0;
      while (!bus.rvalid && t < 20) begin @(negedge clk); t++; end
      if (!bus.rvalid) begin
         chk({nm, "_r_timeout"}, 0, 1);
         if (rq.size() > 0) e = rq.pop_front();
         return;
      end
      if (lat > 0) chk({nm, "_r_lat"}, 32'(cyc - hs), 32'(lat));
      d0 = bus.rdata;
      r0 = bus.rresp;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_r_hold_data"}, bus.rdata, d0);
         chk({nm, "_r_hold_ctl"},
             {28'h0, bus.rvalid, bus.rresp, bus.arready},
             {28'h0, 1'b1, r0, 1'b0});
      end
      e = rq.pop_front();
      chk({nm, "_rdata"}, bus.rdata, e.data);
      chk({nm, "_rresp"}, {30'h0, bus.rresp}, {30'h0, e.resp});
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      chk({nm, "_r_done"}, {31'h0, bus.rvalid}, 0);
   endtask

   initial begin
      int hs;
      int we0;
      int bcyc;
      int rcyc;
      int rv_seen;
      string nm;
      exp_t e;

      vt[0] = '{32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 32'hDEADBEEF, AXI_RESP_OKAY};
      vt[1] = '{32'h104, 32'h11223344, 4'hF, 0, 0, 32'h11223344, AXI_RESP_OKAY};
      vt[2] = '{32'h104, 32'h0000AB00, 4'h2, 0, 0, 32'h1122AB44, AXI_RESP_OKAY};
      vt[3] = '{32'h200, 32'hAAAA5555, 4'hF, 3, 0, 32'hAAAA5555, AXI_RESP_OKAY};
      vt[4] = '{32'h204, 32'h12345678, 4'hF, 0, 3, 32'h12345678, AXI_RESP_OKAY};
      vt[5] = '{32'h10000, 32'hCAFEF00D, 4'hF, 0, 0, 32'h0, AXI_RESP_DECERR};
      vt[6] = '{32'hFFFC, 32'hA5A5A5A5, 4'hF, 0, 0, 32'hA5A5A5A5, AXI_RESP_OKAY};
      vt[7] = '{32'h103, 32'h00000077, 4'h1, 0, 0, 32'hDEADBE77, AXI_RESP_OKAY};
      vt[8] = '{32'hFFFFFFFC, 32'h13579BDF, 4'hF, 2, 1, 32'h0, AXI_RESP_DECERR};

      bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
      bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0;
      bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 0;

      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      chk("rst_readies", {29'h0, bus.arready, bus.awready, bus.wready}, 7);
      chk("rst_valids", {30'h0, bus.rvalid, bus.bvalid}, 0);
      chk("rst_mem", {27'h0, mem_en, mem_we}, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_resps", {28'h0, bus.rresp, bus.bresp}, 0);

      for (int i = 0; i < 9; i++) begin
         nm = $sformatf("v%0d", i);
         we0 = we_cnt;
         drive_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].aw_dly,
                     vt[i].w_dly, vt[i].resp, nm, hs);
         wait_b(hs, 0, nm);
         chk({nm, "_we_pulses"}, 32'(we_cnt - we0),
             (vt[i].resp == AXI_RESP_OKAY) ? 1 : 0);
         drive_read(vt[i].addr, vt[i].rd, vt[i].resp, nm, hs);
         wait_r(hs, 0, (vt[i].resp == AXI_RESP_OKAY) ? 3 : 0, nm);
      end

      // Back-pressure on both response channels.
      drive_write(32'h300, 32'h0BADF00D, 4'hF, 0, 0, AXI_RESP_OKAY, "bp", hs);
      wait_b(hs, 5, "bp");
      drive_read(32'h300, 32'h0BADF00D, AXI_RESP_OKAY, "bp", hs);
      wait_r(hs, 5, 3, "bp");

      // Write commit and read R_MEM collide in the same cycle.
      e.data = 32'h0;
      e.resp = AXI_RESP_OKAY;
      bq.push_back(e);
      e.data = 32'hDEADBE77;
      rq.push_back(e);
      @(negedge clk);
      chk("col_readies", {29'h0, bus.arready, bus.awready, bus.wready}, 7);
      bus.awaddr = 32'h404; bus.wdata = 32'h5A5A0001; bus.wstrb = 4'hF;
      bus.araddr = 32'h100;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
      hs = cyc;
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      bus.bready = 1'b1; bus.rready = 1'b1;
      bcyc = -100;
      rcyc = -100;
      for (int i = 0; i < 10; i++) begin
         if (bus.bvalid && bcyc < 0) begin
            bcyc = cyc;
            e = bq.pop_front();
            chk("col_bresp", {30'h0, bus.bresp}, {30'h0, e.resp});
         end
         if (bus.rvalid && rcyc < 0) begin
            rcyc = cyc;
            e = rq.pop_front();
            chk("col_rdata", bus.rdata, e.data);
            chk("col_rresp", {30'h0, bus.rresp}, {30'h0, e.resp});
         end
         @(negedge clk);
      end
      bus.bready = 1'b0; bus.rready = 1'b0;
      chk("col_b_lat", 32'(bcyc - hs), 2);
      chk("col_r_lat", 32'(rcyc - hs), 4);
      bq.delete();
      rq.delete();
      drive_read(32'h404, 32'h5A5A0001, AXI_RESP_OKAY, "col_after", hs);
      wait_r(hs, 0, 3, "col_after");

      // Reset lands while a read is in R_MEM.
      @(negedge clk);
      bus.araddr = 32'h100;
      bus.arvalid = 1'b1;
      @(negedge clk);
      bus.arvalid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("mid_rst_readies",
          {29'h0, bus.arready, bus.awready, bus.wready}, 7);
      chk("mid_rst_rvalid", {31'h0, bus.rvalid}, 0);
      rv_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.rvalid) rv_seen++;
      end
      chk("mid_rst_no_resp", 32'(rv_seen), 0);
      drive_read(32'h100, 32'hDEADBE77, AXI_RESP_OKAY, "post_rst", hs);
      wait_r(hs, 0, 3, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_lite_bram_slave.md
Name: axi_lite_bram_slave

Overview:
- AXI4-Lite slave that terminates the core's data-memory bus and serves it from a single-port, 1-cycle-latency block RAM.
- Sits directly downstream of the core's MEM stage, on the other side of its ar/r/aw/w/b channels.
- Handles AW and W arriving in either order, byte strobes, address decode errors, and read/write contention on the one RAM port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- MEM_WORDS, 16384, RAM depth in 32-bit words (64 KiB).
- IDX_W, 14, RAM word-index width; must equal clog2(MEM_WORDS).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- s_araddr  in  32  read address
- s_arprot  in  3  ignored
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_awaddr  in  32  write address
- s_awprot  in  3  ignored
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wstrb  in  4  byte enables
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- mem_en  out  1  RAM enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  IDX_W  RAM word index
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after a mem_en cycle

Behaviour:
- Reset (rstn=0 at posedge):
  - both FSMs go to idle; any in-flight transaction is dropped with no response.
  - rvalid=0, bvalid=0, mem_en=0, mem_we=0, rdata=0, rresp=0, bresp=0.
  - arready, awready and wready all read 1 in the first cycle after reset.
- Decode:
  - off = addr - BASE_ADDR (32-bit wrap); idx = off[31:2]; addr[1:0] ignored.
  - In range iff addr >= BASE_ADDR and idx < MEM_WORDS.
- Response codes: OKAY 2'b00 in range; DECERR 2'b11 out of range. SLVERR is never produced.
- Write FSM: W_IDLE -> W_COMMIT -> W_RESP.
  - W_IDLE: awready = !aw_held and wready = !w_held.
  - On each valid&&ready handshake, latch that channel and drop its ready. AW and W may complete in the same cycle or in any order.
  - When both are held, move to W_COMMIT.
  - W_COMMIT (1 cycle): mem_en=1, mem_addr=idx, mem_wdata=wdata. mem_we=wstrb if in range, else mem_we=0 and mem_en=0.
  - W_COMMIT -> W_RESP: bvalid=1, bresp set by decode.
  - W_RESP: hold until bready. Then clear bvalid and the held flags, return to W_IDLE (readies reassert next cycle).
  - Latency: last of AW/W handshakes at cycle N -> RAM write at N+1 -> bvalid at N+2.
- Read FSM: R_IDLE -> R_MEM -> R_WAIT -> R_RESP.
  - R_IDLE: arready=1; on handshake latch araddr and go to R_MEM.
  - R_MEM: mem_en=1, mem_we=0, mem_addr=idx. Skipped with no RAM access if out of range.
  - R_WAIT: capture mem_rdata into rdata (0 if out of range), set rvalid=1 and rresp.
  - R_RESP: hold rdata, rresp and rvalid stable until rready; then go to R_IDLE.
  - Latency: AR handshake at N -> rvalid at N+3.
- Contention: if W_COMMIT and R_MEM occur in the same cycle, the write wins and the read stays in R_MEM one extra cycle. A read never observes a half-applied write.
- Back-pressure:
  - If bready or rready is low, the response holds indefinitely.
  - A new AR is not accepted until R_IDLE.
  - A new AW/W is not accepted until the previous B completes.
- Read and write channels are otherwise independent; one of each may be outstanding at once.
- Only mem_we and mem_en are driven combinationally from state.

Decomposition:
- Shared package: AXI_RESP_OKAY, AXI_RESP_DECERR, the write-state and read-state enums.
- No RTL sub-module is needed.
- The bench supplies a behavioural single-port RAM model, bram_sp_model (1-cycle read, byte-masked write), to pair with this block.

Test Plan:
- Write 0xDEADBEEF, wstrb 4'b1111 to 0x100, then read 0x100 -> bresp=00; rdata=0xDEADBEEF, rresp=00; rvalid exactly 3 cycles after the AR handshake.
- Preload 0x11223344 at 0x104; write 0x0000AB00 with wstrb 4'b0010; read back -> 0x1122AB44.
- AW presented 3 cycles before W, and separately W 3 cycles before AW -> one RAM write per transaction; bvalid 2 cycles after the later handshake.
- Write and read to 0x10000 (idx 16384, out of range) -> bresp=11 with no mem_we pulse; rresp=11 with rdata=0.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata stay stable; no new AW, W or AR accepted.
- Write commit and read to a different address collide in the same cycle -> write lands first; read returns 1 cycle late with correct data. Assert rstn=0 mid-read -> rvalid=0 and all three readies are 1 after reset.
